// File: rtl/udp_gen_pkg.sv
// Shared encodings, limits and PRBS7 helper for the UDP payload generator.
package udp_gen_pkg;

  typedef enum logic [1:0] {
    GEN_INCR  = 2'd0,
    GEN_FIXED = 2'd1,
    GEN_PRBS  = 2'd2,
    GEN_SWEEP = 2'd3
  } gen_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_RDY = 2'd1,
    ST_SEND     = 2'd2,
    ST_GAP      = 2'd3
  } gen_state_e;

  localparam logic [6:0] PRBS_SEED = 7'h7F;

  localparam int unsigned UDP_MIN_LEN = 18;
  localparam int unsigned UDP_MAX_LEN = 1472;

  // Advance a PRBS7 (x^7+x^6+1) register by 8 bits; returns {byte, new_state}, byte MSB first.
  function automatic logic [14:0] prbs7_step8(input logic [6:0] s);
    logic [6:0] st;
    logic [7:0] b;
    logic       fb;
    st = s;
    b  = '0;
    for (int i = 0; i < 8; i++) begin
      fb = st[6] ^ st[5];
      b  = {b[6:0], fb};
      st = {st[5:0], fb};
    end
    return {b, st};
  endfunction

endpackage

// File: rtl/udp_gen_prbs7.sv
// Byte-wide PRBS7 generator: byte_c is the next byte from the current state.
module udp_gen_prbs7
  import udp_gen_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       en,
  output logic [7:0] byte_c
);

  logic [6:0]  state_q;
  logic [14:0] step_c;

  assign step_c = prbs7_step8(state_q);
  assign byte_c = step_c[14:7];

  // Reseed on load, otherwise advance one byte whenever a byte is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PRBS_SEED;
    end else if (load) begin
      state_q <= PRBS_SEED;
    end else if (en) begin
      state_q <= step_c[6:0];
    end
  end

endmodule

// File: rtl/udp_pkt_gen.sv
// UDP payload traffic generator driving the stack's send-side user interface.
module udp_pkt_gen
  import udp_gen_pkg::*;
#(
  parameter int unsigned P_LEN_W   = 16,
  parameter int unsigned P_MIN_LEN = UDP_MIN_LEN,
  parameter int unsigned P_MAX_LEN = UDP_MAX_LEN,
  parameter int unsigned P_GAP_W   = 16,
  parameter int unsigned P_CNT_W   = 32
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic [P_LEN_W-1:0] i_cfg_len,
  input  logic [1:0]         i_cfg_mode,
  input  logic [7:0]         i_cfg_byte,
  input  logic [P_GAP_W-1:0] i_cfg_gap,
  input  logic [P_CNT_W-1:0] i_cfg_pkt_num,
  input  logic               i_send_ready,
  output logic [7:0]         o_send_udp_data,
  output logic [P_LEN_W-1:0] o_send_udp_len,
  output logic               o_send_udp_last,
  output logic               o_send_udp_valid,
  output logic               o_busy,
  output logic               o_done,
  output logic [P_CNT_W-1:0] o_pkt_cnt,
  output logic [P_CNT_W-1:0] o_byte_cnt
);

  localparam logic [P_LEN_W-1:0] MIN_LEN = P_LEN_W'(P_MIN_LEN);
  localparam logic [P_LEN_W-1:0] MAX_LEN = P_LEN_W'(P_MAX_LEN);

  gen_state_e         state_q, state_d;
  gen_mode_e          mode_q;
  logic [7:0]         byte_q;
  logic [P_GAP_W-1:0] gap_q, gap_cnt_q;
  logic [P_CNT_W-1:0] pkt_num_q;
  logic [P_LEN_W-1:0] eff_len_q, sweep_len_q, cur_len_q, idx_q;
  logic               stop_pend_q;

  logic               start_c, fire_c, adv_c, pkt_end_c, done_c, run_end_c;
  logic [P_LEN_W-1:0] cfg_eff_len_c, pkt_len_c, idx_nxt_c, idx_sel_c;
  logic [P_CNT_W-1:0] pkt_cnt_inc_c;
  logic [7:0]         data_nxt_c, prbs_byte_c;
  logic               last_nxt_c;

  // Byte stream from PRBS7; reseeded on every cycle that does not emit a byte.
  udp_gen_prbs7 u_prbs (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .load   (!(fire_c || adv_c)),
    .en     (fire_c || adv_c),
    .byte_c (prbs_byte_c)
  );

  // Derived values: clamped length, next packet length, next byte and its last flag.
  always_comb begin
    cfg_eff_len_c = i_cfg_len;
    if (i_cfg_len < MIN_LEN) cfg_eff_len_c = MIN_LEN;
    else if (i_cfg_len > MAX_LEN) cfg_eff_len_c = MAX_LEN;
    pkt_len_c     = (mode_q == GEN_SWEEP) ? sweep_len_q : eff_len_q;
    pkt_cnt_inc_c = (o_pkt_cnt == '1) ? o_pkt_cnt : o_pkt_cnt + P_CNT_W'(1);
    run_end_c     = ((pkt_num_q != '0) && (pkt_cnt_inc_c == pkt_num_q)) || stop_pend_q || i_stop;
    idx_nxt_c     = idx_q + P_LEN_W'(1);
    idx_sel_c     = fire_c ? '0 : idx_nxt_c;
    last_nxt_c    = fire_c ? (pkt_len_c == P_LEN_W'(1))
                           : (idx_nxt_c == cur_len_q - P_LEN_W'(1));
    case (mode_q)
      GEN_FIXED: data_nxt_c = byte_q;
      GEN_PRBS:  data_nxt_c = prbs_byte_c;
      default:   data_nxt_c = 8'(idx_sel_c);
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic and control strobes.
  always_comb begin
    state_d   = state_q;
    start_c   = 1'b0;
    fire_c    = 1'b0;
    adv_c     = 1'b0;
    pkt_end_c = 1'b0;
    done_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          start_c = 1'b1;
          state_d = ST_WAIT_RDY;
        end
      end
      ST_WAIT_RDY: begin
        if (i_stop) begin
          done_c  = 1'b1;
          state_d = ST_IDLE;
        end else if (i_send_ready) begin
          fire_c  = 1'b1;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (o_send_udp_last) begin
          pkt_end_c = 1'b1;
          if (run_end_c) begin
            done_c  = 1'b1;
            state_d = ST_IDLE;
          end else if (gap_q != '0) begin
            state_d = ST_GAP;
          end else begin
            state_d = ST_WAIT_RDY;
          end
        end else begin
          adv_c = 1'b1;
        end
      end
      ST_GAP: begin
        if (i_stop) begin
          done_c  = 1'b1;
          state_d = ST_IDLE;
        end else if (gap_cnt_q <= P_GAP_W'(1)) begin
          state_d = ST_WAIT_RDY;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Config latch, packet datapath, registered outputs and counters.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mode_q           <= GEN_INCR;
      byte_q           <= '0;
      gap_q            <= '0;
      gap_cnt_q        <= '0;
      pkt_num_q        <= '0;
      eff_len_q        <= '0;
      sweep_len_q      <= '0;
      cur_len_q        <= '0;
      idx_q            <= '0;
      stop_pend_q      <= 1'b0;
      o_send_udp_data  <= '0;
      o_send_udp_len   <= '0;
      o_send_udp_last  <= 1'b0;
      o_send_udp_valid <= 1'b0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
      o_pkt_cnt        <= '0;
      o_byte_cnt       <= '0;
    end else begin
      o_busy <= (state_d != ST_IDLE);
      o_done <= done_c;

      if (start_c) begin
        mode_q      <= gen_mode_e'(i_cfg_mode);
        byte_q      <= i_cfg_byte;
        gap_q       <= i_cfg_gap;
        pkt_num_q   <= i_cfg_pkt_num;
        eff_len_q   <= cfg_eff_len_c;
        sweep_len_q <= MIN_LEN;
        stop_pend_q <= 1'b0;
        o_pkt_cnt   <= '0;
        o_byte_cnt  <= '0;
      end else begin
        if (state_q == ST_SEND && i_stop) stop_pend_q <= 1'b1;
        if (pkt_end_c) o_pkt_cnt <= pkt_cnt_inc_c;
        if (o_send_udp_valid && o_byte_cnt != '1) o_byte_cnt <= o_byte_cnt + P_CNT_W'(1);
      end

      if (pkt_end_c) gap_cnt_q <= gap_q;
      else if (state_q == ST_GAP) gap_cnt_q <= gap_cnt_q - P_GAP_W'(1);

      if (fire_c || adv_c) begin
        o_send_udp_valid <= 1'b1;
        o_send_udp_data  <= data_nxt_c;
        o_send_udp_last  <= last_nxt_c;
        idx_q            <= idx_sel_c;
        if (fire_c) begin
          cur_len_q      <= pkt_len_c;
          o_send_udp_len <= pkt_len_c;
          if (mode_q == GEN_SWEEP)
            sweep_len_q <= (sweep_len_q >= eff_len_q) ? MIN_LEN : sweep_len_q + P_LEN_W'(1);
        end
      end else begin
        o_send_udp_valid <= 1'b0;
        o_send_udp_data  <= '0;
        o_send_udp_last  <= 1'b0;
        o_send_udp_len   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_udp_pkt_gen.sv
// Scoreboard bench for udp_pkt_gen: expected bytes queued at stimulus, popped by the monitor.
module tb_udp_pkt_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start, i_stop, i_send_ready;
  logic [15:0] i_cfg_len;
  logic [1:0]  i_cfg_mode;
  logic [7:0]  i_cfg_byte;
  logic [15:0] i_cfg_gap;
  logic [31:0] i_cfg_pkt_num;
  logic [7:0]  o_send_udp_data;
  logic [15:0] o_send_udp_len;
  logic        o_send_udp_last, o_send_udp_valid, o_busy, o_done;
  logic [31:0] o_pkt_cnt, o_byte_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_cyc = -1;
  int exp_idle = -1;
  bit done_after_last = 1'b1;
  bit prev_valid = 1'b0;
  logic [31:0] exp_q[$];
  bit prbs_seq[0:199];

  always #5 clk = ~clk;

  udp_pkt_gen dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_start          (i_start),
    .i_stop           (i_stop),
    .i_cfg_len        (i_cfg_len),
    .i_cfg_mode       (i_cfg_mode),
    .i_cfg_byte       (i_cfg_byte),
    .i_cfg_gap        (i_cfg_gap),
    .i_cfg_pkt_num    (i_cfg_pkt_num),
    .i_send_ready     (i_send_ready),
    .o_send_udp_data  (o_send_udp_data),
    .o_send_udp_len   (o_send_udp_len),
    .o_send_udp_last  (o_send_udp_last),
    .o_send_udp_valid (o_send_udp_valid),
    .o_busy           (o_busy),
    .o_done           (o_done),
    .o_pkt_cnt        (o_pkt_cnt),
    .o_byte_cnt       (o_byte_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // PRBS7 byte j of a packet, from the sequence recurrence x[n] = x[n-7] ^ x[n-6].
  function automatic logic [7:0] exp_prbs(input int j);
    logic [7:0] b;
    b = '0;
    for (int k = 0; k < 8; k++) b = {b[6:0], prbs_seq[7 + 8*j + k]};
    return b;
  endfunction

  function automatic int clamp_len(input int l);
    if (l < 18) return 18;
    if (l > 1472) return 1472;
    return l;
  endfunction

  // Queue every expected byte of a run as {last, len, data}.
  task automatic push_run(input int mode, input int len, input logic [7:0] fb, input int pkts);
    int eff, sl, plen;
    logic [7:0] d;
    eff = clamp_len(len);
    sl  = 18;
    for (int p = 0; p < pkts; p++) begin
      if (mode == 3) begin
        plen = sl;
        sl = (sl >= eff) ? 18 : sl + 1;
      end else begin
        plen = eff;
      end
      for (int i = 0; i < plen; i++) begin
        if (mode == 1)      d = fb;
        else if (mode == 2) d = exp_prbs(i);
        else                d = 8'(i % 256);
        exp_q.push_back({7'd0, (i == plen - 1), 16'(plen), d});
      end
    end
  endtask

  // Present config, pulse start, then scramble config to show it is latched.
  task automatic do_start(input int mode, input int len, input logic [7:0] fb, input int gap, input int pkts);
    i_cfg_mode    = 2'(mode);
    i_cfg_len     = 16'(len);
    i_cfg_byte    = fb;
    i_cfg_gap     = 16'(gap);
    i_cfg_pkt_num = 32'(pkts);
    last_cyc      = -1;
    exp_idle      = gap + 1;
    @(posedge clk); #1 i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
    i_cfg_mode    = 2'($urandom);
    i_cfg_len     = 16'($urandom_range(18, 60));
    i_cfg_byte    = 8'($urandom);
    i_cfg_gap     = 16'($urandom_range(0, 5));
    i_cfg_pkt_num = 32'($urandom_range(1, 3));
  endtask

  task automatic pulse_stop();
    @(posedge clk); #1 i_stop = 1'b1;
    @(posedge clk); #1 i_stop = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!o_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 32'(o_done), 32'd1);
  endtask

  task automatic wait_bytes(input int cnt);
    int seen, n;
    seen = 0;
    n = 0;
    while (seen < cnt && n < 5000) begin
      @(negedge clk);
      if (o_send_udp_valid) seen++;
      n++;
    end
    check("bytes_seen", 32'(seen), 32'(cnt));
  endtask

  task automatic end_of_run(input string tag, input int pkts, input int bytes);
    check({tag, "_pkt_cnt"}, o_pkt_cnt, 32'(pkts));
    check({tag, "_byte_cnt"}, o_byte_cnt, 32'(bytes));
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
    repeat (2) @(negedge clk);
    check({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: pops the scoreboard on every valid byte and checks spacing and done latency.
  always @(negedge clk) begin
    logic [31:0] e;
    cyc++;
    if (rst_n) begin
      if (o_send_udp_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("byte", {7'd0, o_send_udp_last, o_send_udp_len, o_send_udp_data}, e);
        end
        if (!prev_valid && last_cyc >= 0 && exp_idle >= 0)
          check("idle_gap", 32'(cyc - last_cyc - 1), 32'(exp_idle));
        if (o_send_udp_last) last_cyc = cyc;
      end else begin
        check("idle_len_last", {15'd0, o_send_udp_last, o_send_udp_len}, 32'd0);
      end
      if (o_done && done_after_last)
        check("done_latency", 32'(cyc - last_cyc), 32'd1);
      prev_valid = o_send_udp_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  initial begin
    for (int i = 0; i < 7; i++) prbs_seq[i] = 1'b1;
    for (int i = 7; i < 200; i++) prbs_seq[i] = prbs_seq[i-7] ^ prbs_seq[i-6];

    rst_n = 1'b0;
    i_start = 1'b0; i_stop = 1'b0; i_send_ready = 1'b1;
    i_cfg_len = '0; i_cfg_mode = '0; i_cfg_byte = '0; i_cfg_gap = '0; i_cfg_pkt_num = '0;
    repeat (3) @(negedge clk);
    check("rst_outputs", {o_send_udp_data, 7'd0, o_send_udp_last, o_send_udp_valid,
                          o_busy, o_done, 13'd0}, 32'd0);
    check("rst_len", 32'(o_send_udp_len), 32'd0);
    check("rst_pkt_cnt", o_pkt_cnt, 32'd0);
    check("rst_byte_cnt", o_byte_cnt, 32'd0);
    rst_n = 1'b1;

    // Basic incrementing packet.
    push_run(0, 100, 8'h00, 1);
    do_start(0, 100, 8'h00, 0, 1);
    check("busy_after_start", 32'(o_busy), 32'd1);
    wait_done(500);
    end_of_run("incr100", 1, 100);

    // Clamping at both limits.
    push_run(0, 5, 8'h00, 2);
    do_start(0, 5, 8'h00, 0, 2);
    wait_done(500);
    end_of_run("clamp_lo", 2, 36);
    push_run(0, 2000, 8'h00, 2);
    do_start(0, 2000, 8'h00, 0, 2);
    wait_done(4000);
    end_of_run("clamp_hi", 2, 2944);

    // Length sweep with a gap of 3.
    push_run(3, 20, 8'h00, 5);
    do_start(3, 20, 8'h00, 3, 5);
    wait_done(500);
    end_of_run("sweep", 5, 18 + 19 + 20 + 18 + 19);

    // PRBS and fixed byte patterns.
    push_run(2, 18, 8'h00, 3);
    do_start(2, 18, 8'h00, 0, 3);
    wait_done(500);
    end_of_run("prbs", 3, 54);
    push_run(1, 40, 8'hA5, 2);
    do_start(1, 40, 8'hA5, 1, 2);
    wait_done(500);
    end_of_run("fixed", 2, 80);

    // Backpressure before the packet, ready dropped mid-packet.
    i_send_ready = 1'b0;
    do_start(0, 30, 8'h00, 0, 1);
    repeat (50) @(negedge clk);
    check("bp_hold_valid", 32'(o_send_udp_valid), 32'd0);
    check("bp_hold_busy", 32'(o_busy), 32'd1);
    @(posedge clk); #1 i_send_ready = 1'b1;
    push_run(0, 30, 8'h00, 1);
    @(negedge clk);
    check("bp_pre_valid", 32'(o_send_udp_valid), 32'd0);
    @(negedge clk);
    check("bp_first_valid", 32'(o_send_udp_valid), 32'd1);
    wait_bytes(5);
    i_send_ready = 1'b0;
    wait_done(200);
    end_of_run("bp", 1, 30);
    i_send_ready = 1'b1;

    // Unlimited run: ignored start while busy, stop mid-packet.
    push_run(0, 40, 8'h00, 1);
    do_start(0, 40, 8'h00, 0, 0);
    wait_bytes(5);
    i_cfg_len = 16'd50;
    i_cfg_mode = 2'd1;
    @(posedge clk); #1 i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
    wait_bytes(5);
    pulse_stop();
    wait_done(200);
    end_of_run("stop_send", 1, 40);

    // Stop while in the inter-packet gap.
    done_after_last = 1'b0;
    push_run(0, 18, 8'h00, 1);
    do_start(0, 18, 8'h00, 20, 0);
    wait_bytes(18);
    repeat (4) @(negedge clk);
    check("gap_busy", 32'(o_busy), 32'd1);
    pulse_stop();
    wait_done(20);
    end_of_run("stop_gap", 1, 18);
    done_after_last = 1'b1;

    // Stop in IDLE does nothing.
    pulse_stop();
    repeat (3) @(negedge clk);
    check("idle_stop", {30'd0, o_busy, o_done}, 32'd0);

    // Asynchronous reset mid-packet.
    push_run(0, 100, 8'h00, 1);
    do_start(0, 100, 8'h00, 0, 1);
    wait_bytes(10);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid_last", {30'd0, o_send_udp_valid, o_send_udp_last}, 32'd0);
    check("arst_data_len", {8'd0, o_send_udp_data, o_send_udp_len}, 32'd0);
    check("arst_busy_done", {30'd0, o_busy, o_done}, 32'd0);
    check("arst_cnts", o_pkt_cnt | o_byte_cnt, 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_idle", {30'd0, o_busy, o_send_udp_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
